// File: rtl/timer_counter_if.sv
// CPU data-memory bus slice seen by the timer peripheral.
//   m_data_addr   : byte address from the CPU M stage
//   m_data_wdata  : store data
//   m_data_byteen : byte enables, 4'b0000 means no write
//   rdata         : read data, combinational on m_data_addr
interface timer_counter_if;
  logic [31:0] m_data_addr;
  logic [31:0] m_data_wdata;
  logic [3:0]  m_data_byteen;
  logic [31:0] rdata;

  modport master (output m_data_addr, output m_data_wdata, output m_data_byteen,
                  input rdata);
  modport slave  (input m_data_addr, input m_data_wdata, input m_data_byteen,
                  output rdata);
endinterface

// File: rtl/timer_counter.sv
// Memory-mapped countdown timer with one-shot / auto-reload modes.
// Register window (16 bytes at BASE_ADDR):
//   +0 CTRL   {IM[3], MODE[2:1], EN[0]}  rw
//   +4 PRESET                            rw
//   +8 COUNT                             ro
//   +C reserved, reads 0
// Ports:
//   clk   : system clock, rising edge
//   reset : synchronous, active-high
//   bus   : CPU data bus (slave side), full-word writes only
//   irq   : interrupt request = irq_flag & IM, registered state only
module timer_counter #(
  parameter logic [31:0] BASE_ADDR = 32'h0000_7F00
) (
  input  logic            clk,
  input  logic            reset,
  timer_counter_if.slave  bus,
  output logic            irq
);

  typedef enum logic [1:0] {IDLE, LOAD, CNT, INT} state_t;

  state_t      state_q, state_d;
  logic        en_q, en_d;
  logic [1:0]  mode_q, mode_d;
  logic        im_q, im_d;
  logic [31:0] preset_q, preset_d;
  logic [31:0] count_q, count_d;
  logic        flag_q, flag_d;

  logic        hit, wr, wr_ctrl, wr_preset, set_flag;
  logic [1:0]  off;
  logic        unused_addr_lsb;

  assign hit       = (bus.m_data_addr[31:4] == BASE_ADDR[31:4]);
  assign off       = bus.m_data_addr[3:2];
  assign wr        = hit && (bus.m_data_byteen == 4'b1111);
  assign wr_ctrl   = wr && (off == 2'd0);
  assign wr_preset = wr && (off == 2'd1);
  assign unused_addr_lsb = ^bus.m_data_addr[1:0];

  always_comb begin
    state_d  = state_q;
    en_d     = en_q;
    mode_d   = mode_q;
    im_d     = im_q;
    preset_d = preset_q;
    count_d  = count_q;
    flag_d   = flag_q;
    set_flag = 1'b0;

    case (state_q)
      IDLE: if (en_q) state_d = LOAD;
      LOAD: begin
        count_d = preset_q;
        state_d = CNT;
      end
      CNT: begin
        if (!en_q) begin
          state_d = IDLE;
        end else if (count_q > 32'd1) begin
          count_d = count_q - 32'd1;
        end else begin
          // Reaching 1 (or starting at 0) fires; COUNT never wraps below 0.
          count_d  = 32'd0;
          state_d  = INT;
          set_flag = 1'b1;
        end
      end
      INT: begin
        if (mode_q == 2'b01) begin
          state_d = LOAD;
          flag_d  = 1'b0;
        end else begin
          state_d = IDLE;
          en_d    = 1'b0;
        end
      end
      default: state_d = IDLE;
    endcase

    // Software CTRL write overrides the hardware EN clear in the same cycle.
    if (wr_ctrl) begin
      en_d   = bus.m_data_wdata[0];
      mode_d = bus.m_data_wdata[2:1];
      im_d   = bus.m_data_wdata[3];
      flag_d = 1'b0;
    end
    if (wr_preset) preset_d = bus.m_data_wdata;
    // Entering INT beats a simultaneous clear.
    if (set_flag) flag_d = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= IDLE;
      en_q     <= 1'b0;
      mode_q   <= 2'b00;
      im_q     <= 1'b0;
      preset_q <= 32'd0;
      count_q  <= 32'd0;
      flag_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      en_q     <= en_d;
      mode_q   <= mode_d;
      im_q     <= im_d;
      preset_q <= preset_d;
      count_q  <= count_d;
      flag_q   <= flag_d;
    end
  end

  always_comb begin
    bus.rdata = 32'd0;
    if (hit) begin
      case (off)
        2'd0:    bus.rdata = {28'd0, im_q, mode_q, en_q};
        2'd1:    bus.rdata = preset_q;
        2'd2:    bus.rdata = count_q;
        default: bus.rdata = 32'd0;
      endcase
    end
  end

  assign irq = flag_q & im_q;

endmodule

// File: tb/tb_timer_counter.sv
module tb_timer_counter;
  localparam logic [31:0] A_CTRL = 32'h7F00, A_PRE = 32'h7F04,
                          A_CNT  = 32'h7F08, A_RSV = 32'h7F0C, A_MISS = 32'h7F10;
  localparam int P_IDLE = 0, P_LOAD = 1, P_CNT = 2, P_INT = 3;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic irq;
  timer_counter_if bus_if ();

  timer_counter #(.BASE_ADDR(32'h0000_7F00)) dut (
    .clk(clk), .reset(reset), .bus(bus_if.slave), .irq(irq)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;
  logic [31:0] r_obs;
  logic        q_obs;
  int pulses;

  // Reference model
  int          m_phase;
  logic        m_en, m_im, m_flag;
  logic [1:0]  m_mode;
  logic [31:0] m_preset, m_count;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_phase = P_IDLE; m_en = 0; m_im = 0; m_flag = 0; m_mode = 0;
    m_preset = 0; m_count = 0;
  endtask

  function automatic logic [31:0] model_read(input logic [31:0] a);
    if (a[31:4] != 28'h00007F0) return 32'd0;
    case (a[3:2])
      2'd0: return {28'd0, m_im, m_mode, m_en};
      2'd1: return m_preset;
      2'd2: return m_count;
      default: return 32'd0;
    endcase
  endfunction

  task automatic model_step(input logic [31:0] a, input logic [31:0] w, input logic [3:0] be);
    bit wr, fire;
    wr = (a[31:4] == 28'h00007F0) && (be == 4'hF);
    fire = 0;
    if (m_phase == P_IDLE) begin
      if (m_en) m_phase = P_LOAD;
    end else if (m_phase == P_LOAD) begin
      m_count = m_preset; m_phase = P_CNT;
    end else if (m_phase == P_CNT) begin
      if (!m_en) m_phase = P_IDLE;
      else if (m_count > 1) m_count = m_count - 1;
      else begin m_count = 0; m_phase = P_INT; fire = 1; end
    end else begin
      if (m_mode == 2'b01) begin m_phase = P_LOAD; m_flag = 0; end
      else begin m_phase = P_IDLE; m_en = 0; end
    end
    if (wr && a[3:2] == 2'd0) begin
      m_en = w[0]; m_mode = w[2:1]; m_im = w[3]; m_flag = 0;
    end
    if (wr && a[3:2] == 2'd1) m_preset = w;
    if (fire) m_flag = 1;
  endtask

  // One bus cycle: rdata sampled before the edge, irq after it.
  task automatic cyc_r(input logic [31:0] a, input logic [31:0] w, input logic [3:0] be,
                       input logic rst);
    bus_if.m_data_addr = a; bus_if.m_data_wdata = w; bus_if.m_data_byteen = be;
    reset = rst;
    #1;
    r_obs = bus_if.rdata;
    check("rdata_model", r_obs, model_read(a));
    @(posedge clk);
    if (rst) model_reset(); else model_step(a, w, be);
    #1;
    q_obs = irq;
    check("irq_model", {31'd0, q_obs}, {31'd0, m_flag & m_im});
  endtask

  task automatic cyc(input logic [31:0] a, input logic [31:0] w, input logic [3:0] be);
    cyc_r(a, w, be, 1'b0);
  endtask
  task automatic sw(input logic [31:0] a, input logic [31:0] w);
    cyc(a, w, 4'hF);
  endtask
  task automatic rd(input logic [31:0] a);
    cyc(a, 32'd0, 4'h0);
  endtask

  initial begin
    logic [31:0] a, w;
    logic [3:0]  be;
    int op;
    model_reset();
    bus_if.m_data_addr = 0; bus_if.m_data_wdata = 0; bus_if.m_data_byteen = 0;
    @(posedge clk); #1;

    // Reset state
    cyc_r(A_CTRL, 0, 0, 1'b1);
    cyc_r(A_CTRL, 0, 0, 1'b1);
    rd(A_CTRL); check("rst_ctrl", r_obs, 0);
    rd(A_PRE);  check("rst_preset", r_obs, 0);
    rd(A_CNT);  check("rst_count", r_obs, 0);
    rd(A_RSV);  check("rst_rsv", r_obs, 0);
    rd(A_MISS); check("rst_miss", r_obs, 0);
    check("rst_irq", {31'd0, q_obs}, 0);

    // One-shot, PRESET=5
    sw(A_PRE, 5);
    sw(A_CTRL, 32'h9);
    rd(A_CNT); rd(A_CNT);
    for (int i = 0; i < 5; i++) begin
      rd(A_CNT);
      check("os_count", r_obs, 32'(5 - i));
      check("os_irq", {31'd0, q_obs}, (i == 4) ? 1 : 0);
    end
    rd(A_CTRL);
    rd(A_CTRL); check("os_ctrl_en_clr", r_obs, 32'h8);
    check("os_irq_held", {31'd0, q_obs}, 1);
    sw(A_CTRL, 0); check("os_irq_clear", {31'd0, q_obs}, 0);

    // Auto-reload, PRESET=3
    sw(A_PRE, 3);
    sw(A_CTRL, 32'hB);
    pulses = 0;
    for (int i = 0; i < 15; i++) begin rd(A_CNT); pulses += int'(q_obs); end
    check("ar_pulses", pulses, 3);
    sw(A_CTRL, 32'h3);
    pulses = 0;
    for (int i = 0; i < 15; i++) begin rd(A_CNT); pulses += int'(q_obs); end
    check("ar_masked", pulses, 0);
    sw(A_CTRL, 0);
    for (int i = 0; i < 4; i++) rd(A_CNT);

    // PRESET 0 and 1
    for (int p = 0; p < 2; p++) begin
      sw(A_PRE, 32'(p));
      sw(A_CTRL, 32'h9);
      for (int i = 0; i < 3; i++) begin
        rd(A_CNT);
        check("edge_irq", {31'd0, q_obs}, (i == 2) ? 1 : 0);
      end
      sw(A_CTRL, 0); rd(A_CNT); rd(A_CNT);
    end

    // Max preset
    sw(A_PRE, 32'hFFFF_FFFF);
    sw(A_CTRL, 32'h1);
    rd(A_CNT); rd(A_CNT);
    rd(A_CNT); check("max_load", r_obs, 32'hFFFF_FFFF);
    rd(A_CNT); check("max_dec", r_obs, 32'hFFFF_FFFE);
    sw(A_CTRL, 0); rd(A_CNT); rd(A_CNT);

    // Partial write ignored
    cyc(A_CTRL, 32'h9, 4'b0001);
    rd(A_CTRL); check("byte_wr_ignored", r_obs, 0);

    // COUNT write ignored
    sw(A_PRE, 4);
    sw(A_CTRL, 32'h1);
    rd(A_CNT); rd(A_CNT);
    for (int i = 0; i < 4; i++) begin
      if (i == 0) sw(A_CNT, 32'h77); else rd(A_CNT);
      check("cnt_wr_ignored", r_obs, 32'(4 - i));
    end
    sw(A_CTRL, 0); rd(A_CNT); rd(A_CNT); rd(A_CNT);

    // PRESET rewrite mid-count, auto-reload with IM
    sw(A_PRE, 10);
    sw(A_CTRL, 32'hB);
    rd(A_CNT); rd(A_CNT);
    rd(A_CNT); check("pre_rw_start", r_obs, 10);
    sw(A_PRE, 2);
    rd(A_CNT); check("pre_rw_keep", r_obs, 8);
    for (int i = 0; i < 40 && !q_obs; i++) rd(A_CNT);
    check("pre_rw_irq_seen", {31'd0, q_obs}, 1);
    rd(A_CNT); rd(A_CNT);
    rd(A_CNT); check("pre_rw_reload", r_obs, 2);
    sw(A_CTRL, 0); for (int i = 0; i < 4; i++) rd(A_CNT);

    // Pause and resume, then reset mid-count
    sw(A_PRE, 8);
    sw(A_CTRL, 32'h1);
    rd(A_CNT); rd(A_CNT); rd(A_CNT); rd(A_CNT);
    sw(A_CTRL, 0);
    for (int i = 0; i < 3; i++) begin rd(A_CNT); check("pause_frozen", r_obs, 5); end
    sw(A_CTRL, 32'h9);
    rd(A_CNT); rd(A_CNT);
    rd(A_CNT); check("resume_reload", r_obs, 8);
    rd(A_CNT);
    cyc_r(A_CNT, 0, 0, 1'b1);
    check("midrst_irq", {31'd0, q_obs}, 0);
    rd(A_CTRL); check("midrst_ctrl", r_obs, 0);
    rd(A_PRE);  check("midrst_preset", r_obs, 0);
    rd(A_CNT);  check("midrst_count", r_obs, 0);

    // Randomized traffic against the model
    for (int n = 0; n < 600; n++) begin
      op = int'($urandom_range(0, 9));
      a  = {28'h00007F0, 2'($urandom_range(0, 3)), 2'b00};
      w  = $urandom;
      be = 4'hF;
      case (op)
        0, 1, 2: begin a = A_CTRL; sw(a, w); end
        3: sw(A_PRE, 32'($urandom_range(0, 6)));
        4: begin be = 4'($urandom_range(1, 14)); cyc(a, w, be); end
        5: sw(($urandom_range(0, 1) != 0) ? A_CNT : A_RSV, w);
        6: if ($urandom_range(0, 15) == 0) cyc_r(a, 0, 0, 1'b1); else rd(a);
        7: rd(($urandom_range(0, 1) != 0) ? A_MISS : $urandom);
        default: rd(a);
      endcase
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
